systolic_seq_ctrl: RTL

Sequencer between the SPI-side matrix storage and the NxN systolic MAC array.
- On a start command it clears the PE accumulators, reads A columns / B rows out of storage, applies per-lane diagonal skew and drives the array edges.
- It waits for the wavefront to drain, pulses a capture strobe to latch C into the result registers, then raises done/irq.
- Sits inside the SPI wrapper: command-register side talks to the SPI controller, feed side to the array.

---
 rtl/systolic_pkg.sv | 25 ++
 rtl/skew_delay_line.sv | 45 ++++
 rtl/systolic_seq_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: state encoding,
// default geometry and the drain length derived from the array size.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        CAPTURE,
        DONE
    } seq_state_t;

    localparam int N_DEF   = 4;
    localparam int A_W_DEF = 16;
    localparam int B_W_DEF = 8;

    // The last skewed element needs 2N cycles to reach the far corner PE.
    function automatic int drain_cyc(input int n);
        return 2 * n;
    endfunction

    localparam int DRAIN_CYC_DEF = drain_cyc(N_DEF);

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane data + valid delay line used to build the diagonal wavefront.
// DEPTH=0 is a pure passthrough. Data is forced to zero whenever valid is low.
module skew_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] din,
    input  logic                vld_in,
    output logic signed [W-1:0] dout,
    output logic                vld_out
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = ^{clk, rst_n};
            assign vld_out     = vld_in;
            assign dout        = vld_in ? din : '0;
        end else begin : g_dly
            logic signed [W-1:0] data_pn [DEPTH];
            logic [DEPTH-1:0]    vld_pn;

            // Shift data and valid together; reset flushes both.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_pn <= '0;
                    for (int s = 0; s < DEPTH; s++) data_pn[s] <= '0;
                end else begin
                    vld_pn[0]  <= vld_in;
                    data_pn[0] <= din;
                    for (int s = 1; s < DEPTH; s++) begin
                        vld_pn[s]  <= vld_pn[s-1];
                        data_pn[s] <= data_pn[s-1];
                    end
                end
            end

            assign vld_out = vld_pn[DEPTH-1];
            assign dout    = vld_out ? data_pn[DEPTH-1] : '0;
        end
    endgenerate

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer between matrix storage and the NxN systolic MAC array:
// clear accumulators, stream A columns / B rows with diagonal skew,
// wait for the wavefront to drain, strobe capture, then signal done/irq.
// Optional build macro SYS_PERF_CNT_EN adds job and busy-cycle counters.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             irq_ack,
    output logic             busy,
    output logic             done,
    output logic             irq,
    output logic             start_ovr,
    output logic             mem_rd_en,
    output logic [IDX_W-1:0] mem_rd_idx,
    input  logic [N*A_W-1:0] a_col_data,
    input  logic [N*B_W-1:0] b_row_data,
    output logic [N*A_W-1:0] sys_a_west,
    output logic [N*B_W-1:0] sys_b_north,
    output logic [N-1:0]     sys_feed_vld,
    output logic             sys_acc_clr,
    output logic             sys_capture
`ifdef SYS_PERF_CNT_EN
    ,
    output logic [15:0]      perf_jobs,
    output logic [31:0]      perf_busy_cyc
`endif
);

    localparam int DRAIN_CYC = drain_cyc(N);
    localparam int CNT_W     = $clog2(DRAIN_CYC);

    seq_state_t       state;
    logic [CNT_W-1:0] drain_cnt;
    logic             rd_vld_p0;
    logic [N-1:0]     a_vld;
    logic [N-1:0]     b_vld;

    // Job sequencing with registered control outputs, irq and overrun flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            irq         <= 1'b0;
            start_ovr   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_idx  <= '0;
            sys_acc_clr <= 1'b0;
            sys_capture <= 1'b0;
        end else begin
            if (start && state != IDLE) start_ovr <= 1'b1;
            if (irq_ack) irq <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= CLEAR;
                        busy        <= 1'b1;
                        sys_acc_clr <= 1'b1;
                        start_ovr   <= 1'b0;
                        irq         <= 1'b0;
                    end
                end
                CLEAR: begin
                    sys_acc_clr <= 1'b0;
                    mem_rd_en   <= 1'b1;
                    mem_rd_idx  <= '0;
                    state       <= FEED;
                end
                FEED: begin
                    if (mem_rd_idx == IDX_W'(N-1)) begin
                        mem_rd_en  <= 1'b0;
                        mem_rd_idx <= '0;
                        drain_cnt  <= '0;
                        state      <= DRAIN;
                    end else begin
                        mem_rd_idx <= mem_rd_idx + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == CNT_W'(DRAIN_CYC-1)) begin
                        sys_capture <= 1'b1;
                        state       <= CAPTURE;
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    sys_capture <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    irq   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage data arrives one cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) rd_vld_p0 <= 1'b0;
        else        rd_vld_p0 <= mem_rd_en;
    end

    // Lane i of A and lane j of B get i / j extra cycles of delay.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(.W(A_W), .DEPTH(i)) u_skew_a (
            .clk     (clk),
            .rst_n   (rst_n),
            .din     (a_col_data[i*A_W +: A_W]),
            .vld_in  (rd_vld_p0),
            .dout    (sys_a_west[i*A_W +: A_W]),
            .vld_out (a_vld[i])
        );
        skew_delay_line #(.W(B_W), .DEPTH(i)) u_skew_b (
            .clk     (clk),
            .rst_n   (rst_n),
            .din     (b_row_data[i*B_W +: B_W]),
            .vld_in  (rd_vld_p0),
            .dout    (sys_b_north[i*B_W +: B_W]),
            .vld_out (b_vld[i])
        );
        assign sys_feed_vld[i] = a_vld[i] & b_vld[i];
    end

`ifdef SYS_PERF_CNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Job count wraps; busy-cycle count saturates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_jobs     <= '0;
            perf_busy_cyc <= '0;
        end else begin
            if (state == DONE) perf_jobs <= perf_jobs + 16'd1;
            if (busy) perf_busy_cyc <= sat_inc32(perf_busy_cyc);
        end
    end
`endif

endmodule
